wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 38 +++
 rtl/wb_arbiter.sv | 115 +++++++++++
 tb/tb_wb_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Result bus between the integer/FPU result sources and the register-file write arbiter.
interface wb_arbiter_if;
  logic        ex_u_valid;
  logic [4:0]  ex_u_rt;
  logic [31:0] ex_u_data;
  logic        ex_l_valid;
  logic [4:0]  ex_l_rt;
  logic [31:0] ex_l_data;
  logic        fpu_u_valid;
  logic [4:0]  fpu_u_rt;
  logic [31:0] fpu_u_data;
  logic        fpu_l_valid;
  logic [4:0]  fpu_l_rt;
  logic [31:0] fpu_l_data;
  logic        wr0_en;
  logic [4:0]  wr0_addr;
  logic [31:0] wr0_data;
  logic        wr1_en;
  logic [4:0]  wr1_addr;
  logic [31:0] wr1_data;
  logic        interlock;
  logic [31:0] pending;
  logic        overflow;

  modport master (
    output ex_u_valid, ex_u_rt, ex_u_data, ex_l_valid, ex_l_rt, ex_l_data,
           fpu_u_valid, fpu_u_rt, fpu_u_data, fpu_l_valid, fpu_l_rt, fpu_l_data,
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           interlock, pending, overflow
  );

  modport slave (
    input  ex_u_valid, ex_u_rt, ex_u_data, ex_l_valid, ex_l_rt, ex_l_data,
           fpu_u_valid, fpu_u_rt, fpu_u_data, fpu_l_valid, fpu_l_rt, fpu_l_data,
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           interlock, pending, overflow
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-port register-file writeback arbiter: integer results write next cycle,
// FPU results are queued in a circular buffer and drained into idle write ports.
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned HWM        = FIFO_DEPTH - 4
) (
  input  logic        clk,
  input  logic        rstn,
  wb_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [RW-1:0] rt;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_wr0_en;
  logic          r_wr1_en;
  entry_t        r_wr0;
  entry_t        r_wr1;

  entry_t        w_ex_u, w_ex_l, w_fpu_u, w_fpu_l;
  entry_t        w_head, w_next, w_port0, w_port1;
  logic          w_p0_fifo, w_p1_fifo, w_en0, w_en1;
  logic          w_push_u, w_push_l, w_drop;
  logic [CW-1:0] w_pops, w_pushes, w_free;
  logic [AW-1:0] w_l_ptr;
  logic [31:0]   w_pending;

  assign w_ex_u  = {bus.ex_u_rt,  bus.ex_u_data};
  assign w_ex_l  = {bus.ex_l_rt,  bus.ex_l_data};
  assign w_fpu_u = {bus.fpu_u_rt, bus.fpu_u_data};
  assign w_fpu_l = {bus.fpu_l_rt, bus.fpu_l_data};

  // Port selection: integer results first, idle ports pull buffered entries in order.
  always_comb begin
    w_head    = r_mem[r_rd_ptr];
    w_next    = r_mem[r_rd_ptr + AW'(1)];
    w_p0_fifo = !bus.ex_u_valid && (r_count != '0);
    w_p1_fifo = !bus.ex_l_valid && (r_count > CW'(w_p0_fifo));
    w_en0     = bus.ex_u_valid || w_p0_fifo;
    w_en1     = bus.ex_l_valid || w_p1_fifo;
    w_port0   = bus.ex_u_valid ? w_ex_u : w_head;
    w_port1   = bus.ex_l_valid ? w_ex_l : (w_p0_fifo ? w_next : w_head);
    w_pops    = CW'(w_p0_fifo) + CW'(w_p1_fifo);
  end

  // Space counts slots freed by this cycle's pops; upper slot claims space first.
  always_comb begin
    w_free   = CW'(FIFO_DEPTH) - r_count + w_pops;
    w_push_u = bus.fpu_u_valid && (w_free != '0);
    w_push_l = bus.fpu_l_valid && (w_free > CW'(w_push_u));
    w_pushes = CW'(w_push_u) + CW'(w_push_l);
    w_drop   = (bus.fpu_u_valid && !w_push_u) || (bus.fpu_l_valid && !w_push_l);
    w_l_ptr  = r_wr_ptr + AW'(w_push_u);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_wr0_en   <= 1'b0;
      r_wr1_en   <= 1'b0;
    end else begin
      r_rd_ptr   <= r_rd_ptr + AW'(w_pops);
      r_wr_ptr   <= r_wr_ptr + AW'(w_pushes);
      r_count    <= r_count + w_pushes - w_pops;
      r_overflow <= r_overflow | w_drop;
      // Same-register collision: port 1 carries the younger write.
      r_wr0_en   <= w_en0 && !(w_en1 && (w_port0.rt == w_port1.rt));
      r_wr1_en   <= w_en1;
    end
  end

  always_ff @(posedge clk) begin
    r_wr0 <= w_port0;
    r_wr1 <= w_port1;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      if (w_push_u) r_mem[r_wr_ptr] <= w_fpu_u;
      if (w_push_l) r_mem[w_l_ptr]  <= w_fpu_l;
    end
  end

  // Scoreboard of destinations held by live buffer entries.
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (CW'(AW'(AW'(i) - r_rd_ptr)) < r_count) w_pending[r_mem[i].rt] = 1'b1;
    end
  end

  assign bus.wr0_en    = r_wr0_en;
  assign bus.wr0_addr  = r_wr0.rt;
  assign bus.wr0_data  = r_wr0.data;
  assign bus.wr1_en    = r_wr1_en;
  assign bus.wr1_addr  = r_wr1.rt;
  assign bus.wr1_data  = r_wr1.data;
  assign bus.interlock = (r_count >= CW'(HWM));
  assign bus.pending   = w_pending;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// overflow/reset sequences, and random traffic against a queue-based model.
module tb_wb_arbiter;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned HWM   = 4;

  typedef struct packed {
    bit rstn;
    bit euv; bit [4:0] eur; bit [31:0] eud;
    bit elv; bit [4:0] elr; bit [31:0] eld;
    bit fuv; bit [4:0] fur; bit [31:0] fud;
    bit flv; bit [4:0] flr; bit [31:0] fld;
  } stim_t;

  typedef struct packed {
    bit e0; bit [4:0] a0; bit [31:0] d0;
    bit e1; bit [4:0] a1; bit [31:0] d1;
    bit [31:0] pend; bit il; bit ovf;
  } out_t;

  typedef struct packed { stim_t in; out_t exp; } vec_t;
  typedef struct packed { bit [4:0] rt; bit [31:0] d; } ent_t;

  logic clk = 1'b0;
  logic rstn;
  wb_arbiter_if bus();

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .HWM(HWM)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  ent_t mq[$];
  bit   m_ovf;
  vec_t tbl [13];

  function automatic stim_t st(bit euv, bit [4:0] eur, bit [31:0] eud,
                               bit elv, bit [4:0] elr, bit [31:0] eld,
                               bit fuv, bit [4:0] fur, bit [31:0] fud,
                               bit flv, bit [4:0] flr, bit [31:0] fld);
    stim_t s;
    s = {1'b1, euv, eur, eud, elv, elr, eld, fuv, fur, fud, flv, flr, fld};
    return s;
  endfunction

  function automatic stim_t st_idle();
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t st_rst();
    stim_t s;
    s = st(1, 1, 32'h1, 1, 2, 32'h2, 1, 3, 32'h3, 1, 4, 32'h4);
    s.rstn = 1'b0;
    return s;
  endfunction

  function automatic out_t ot(bit e0, bit [4:0] a0, bit [31:0] d0,
                              bit e1, bit [4:0] a1, bit [31:0] d1,
                              bit [31:0] pend, bit il, bit ovf);
    out_t o;
    o = {e0, a0, d0, e1, a1, d1, pend, il, ovf};
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    rstn            = s.rstn;
    bus.ex_u_valid  = s.euv; bus.ex_u_rt  = s.eur; bus.ex_u_data  = s.eud;
    bus.ex_l_valid  = s.elv; bus.ex_l_rt  = s.elr; bus.ex_l_data  = s.eld;
    bus.fpu_u_valid = s.fuv; bus.fpu_u_rt = s.fur; bus.fpu_u_data = s.fud;
    bus.fpu_l_valid = s.flv; bus.fpu_l_rt = s.flr; bus.fpu_l_data = s.fld;
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".wr0_en"}, 64'(bus.wr0_en), 64'(e.e0));
    if (e.e0) begin
      chk({tag, ".wr0_addr"}, 64'(bus.wr0_addr), 64'(e.a0));
      chk({tag, ".wr0_data"}, 64'(bus.wr0_data), 64'(e.d0));
    end
    chk({tag, ".wr1_en"}, 64'(bus.wr1_en), 64'(e.e1));
    if (e.e1) begin
      chk({tag, ".wr1_addr"}, 64'(bus.wr1_addr), 64'(e.a1));
      chk({tag, ".wr1_data"}, 64'(bus.wr1_data), 64'(e.d1));
    end
    chk({tag, ".pending"},   64'(bus.pending),   64'(e.pend));
    chk({tag, ".interlock"}, 64'(bus.interlock), 64'(e.il));
    chk({tag, ".overflow"},  64'(bus.overflow),  64'(e.ovf));
  endtask

  task automatic run_row(input string tag, input stim_t s, input out_t e);
    drive(s);
    @(posedge clk);
    #1;
    check_out(tag, e);
  endtask

  // Reference: a plain queue of {rt,data}; ports pull from the front, pushes append.
  task automatic model_step(input stim_t s, output out_t o);
    int   taken;
    ent_t p0, p1;
    bit   e0, e1;
    o = '0; taken = 0; e0 = 0; e1 = 0; p0 = '0; p1 = '0;
    if (!s.rstn) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (s.euv) begin e0 = 1; p0 = {s.eur, s.eud}; end
      else if (taken < mq.size()) begin e0 = 1; p0 = mq[taken]; taken++; end
      if (s.elv) begin e1 = 1; p1 = {s.elr, s.eld}; end
      else if (taken < mq.size()) begin e1 = 1; p1 = mq[taken]; taken++; end
      repeat (taken) void'(mq.pop_front());
      if (s.fuv) begin
        if (mq.size() < int'(DEPTH)) mq.push_back({s.fur, s.fud}); else m_ovf = 1;
      end
      if (s.flv) begin
        if (mq.size() < int'(DEPTH)) mq.push_back({s.flr, s.fld}); else m_ovf = 1;
      end
      o.e0 = e0 && !(e1 && (p0.rt == p1.rt));
      o.a0 = p0.rt; o.d0 = p0.d;
      o.e1 = e1;
      o.a1 = p1.rt; o.d1 = p1.d;
    end
    foreach (mq[i]) o.pend[mq[i].rt] = 1'b1;
    o.il  = (mq.size() >= int'(HWM));
    o.ovf = m_ovf;
  endtask

  function automatic bit [4:0] rnd_rt();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t       s;
    out_t        e;
    int          n;
    int          a;
    int unsigned pe, pf;

    // Directed vectors: integer pass-through, FPU buffering, mixing, collision, rt=0, duplicates.
    tbl[0]  = {st_rst(), ot(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = {st(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0, 0), ot(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0)};
    tbl[2]  = {st(0, 0, 0, 0, 0, 0, 1, 5, 32'hA, 1, 6, 32'hB), ot(0, 0, 0, 0, 0, 0, 32'h60, 0, 0)};
    tbl[3]  = {st_idle(), ot(1, 5, 32'hA, 1, 6, 32'hB, 0, 0, 0)};
    tbl[4]  = {st(0, 0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0), ot(0, 0, 0, 0, 0, 0, 32'h80, 0, 0)};
    tbl[5]  = {st(1, 8, 32'h88, 0, 0, 0, 0, 0, 0, 0, 0, 0), ot(1, 8, 32'h88, 1, 7, 32'h77, 0, 0, 0)};
    tbl[6]  = {st(0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0), ot(0, 0, 0, 0, 0, 0, 32'h200, 0, 0)};
    tbl[7]  = {st(0, 0, 0, 1, 9, 32'h55, 0, 0, 0, 0, 0, 0), ot(0, 0, 0, 1, 9, 32'h55, 0, 0, 0)};
    tbl[8]  = {st(1, 0, 32'h1, 0, 0, 0, 0, 0, 0, 1, 0, 32'hC), ot(1, 0, 32'h1, 0, 0, 0, 32'h1, 0, 0)};
    tbl[9]  = {st_idle(), ot(1, 0, 32'hC, 0, 0, 0, 0, 0, 0)};
    tbl[10] = {st(0, 0, 0, 0, 0, 0, 1, 2, 32'hD1, 1, 2, 32'hD2), ot(0, 0, 0, 0, 0, 0, 32'h4, 0, 0)};
    tbl[11] = {st(1, 1, 32'hE0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ot(1, 1, 32'hE0, 1, 2, 32'hD1, 32'h4, 0, 0)};
    tbl[12] = {st_idle(), ot(1, 2, 32'hD2, 0, 0, 0, 0, 0, 0)};

    drive(st_rst());
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) run_row($sformatf("tbl[%0d]", i), tbl[i].in, tbl[i].exp);

    // Fill to full under integer traffic; the fifth cycle's pushes are dropped.
    run_row("ovf.rst", st_rst(), ot(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      a = 16 + 2 * k - 2;
      n = (2 * k > 8) ? 8 : 2 * k;
      s = st(1, 10, 32'hA0 + 32'(k), 1, 11, 32'hB0 + 32'(k),
             1, 5'(a), 32'h1000 + 32'(a), 1, 5'(a + 1), 32'h1000 + 32'(a + 1));
      e = ot(1, 10, 32'hA0 + 32'(k), 1, 11, 32'hB0 + 32'(k),
             32'(((64'd1 << n) - 64'd1) << 16), (n >= 4), (k == 5));
      run_row($sformatf("ovf.fill[%0d]", k), s, e);
    end
    // Drain two per cycle; interlock clears once fewer than HWM entries remain.
    for (int d = 1; d <= 4; d++) begin
      a = 16 + 2 * (d - 1);
      n = 8 - 2 * d;
      e = ot(1, 5'(a), 32'h1000 + 32'(a), 1, 5'(a + 1), 32'h1000 + 32'(a + 1),
             32'(((64'd1 << n) - 64'd1) << (16 + 2 * d)), (n >= 4), 1);
      run_row($sformatf("ovf.drain[%0d]", d), st_idle(), e);
    end

    // Park five entries, then reset mid-stream with all inputs active.
    run_row("rst.fill1", st(1, 20, 32'hF0, 1, 21, 32'hF1, 1, 1, 32'h1, 1, 2, 32'h2),
            ot(1, 20, 32'hF0, 1, 21, 32'hF1, 32'h6, 0, 1));
    run_row("rst.fill2", st(1, 20, 32'hF0, 1, 21, 32'hF1, 1, 3, 32'h3, 1, 4, 32'h4),
            ot(1, 20, 32'hF0, 1, 21, 32'hF1, 32'h1E, 1, 1));
    run_row("rst.fill3", st(1, 20, 32'hF0, 1, 21, 32'hF1, 1, 5, 32'h5, 0, 0, 0),
            ot(1, 20, 32'hF0, 1, 21, 32'hF1, 32'h3E, 1, 1));
    run_row("rst.pulse", st_rst(), ot(0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_row("rst.after", st_idle(), ot(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Random traffic in phases (congested / mixed / draining) against the queue model.
    model_step(st_rst(), e);
    run_row("rnd.rst", st_rst(), e);
    for (int i = 0; i < 600; i++) begin
      case ((i / 50) % 3)
        0:       begin pe = 85; pf = 75; end
        1:       begin pe = 50; pf = 50; end
        default: begin pe = 15; pf = 15; end
      endcase
      s      = st_idle();
      s.rstn = ($urandom_range(0, 99) != 0);
      s.euv  = ($urandom_range(0, 99) < pe); s.eur = rnd_rt(); s.eud = $urandom;
      s.elv  = ($urandom_range(0, 99) < pe); s.elr = rnd_rt(); s.eld = $urandom;
      s.fuv  = ($urandom_range(0, 99) < pf); s.fur = rnd_rt(); s.fud = $urandom;
      s.flv  = ($urandom_range(0, 99) < pf); s.flr = rnd_rt(); s.fld = $urandom;
      model_step(s, e);
      run_row($sformatf("rnd[%0d]", i), s, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
